// File: rtl/stream_fifo_param.sv
// rtl/stream_fifo_param.sv - parametrised valid/ready stream FIFO with wrap-bit pointers.
// Optional almost-full/almost-empty watermarks are enabled by STREAM_FIFO_PARAM_WATERMARK_EN.
module stream_fifo_param #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 16,
  parameter int AFULL_LEVEL  = 12,
  parameter int AEMPTY_LEVEL = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       io_push_valid,
  output logic                       io_push_ready,
  input  logic [WIDTH-1:0]           io_push_payload,
  output logic                       io_pop_valid,
  input  logic                       io_pop_ready,
  output logic [WIDTH-1:0]           io_pop_payload,
  input  logic                       io_flush,
  output logic [$clog2(DEPTH):0]     io_occupancy,
  output logic [$clog2(DEPTH):0]     io_availability,
  output logic                       io_almostFull,
  output logic                       io_almostEmpty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_q;
  logic [AW:0]      wptr, rptr, rptr_next, occupancy;
  logic             hazard_q;
  logic             full, empty, pushing, popping;

  assign occupancy = wptr - rptr;
  assign full      = (occupancy == DEPTH_W);
  assign empty     = (occupancy == '0);

  assign io_push_ready = !full && !io_flush;
  // A freshly written word is not yet visible in the read register for one cycle.
  assign io_pop_valid  = !empty && !hazard_q && !io_flush;

  assign pushing = io_push_valid && io_push_ready;
  assign popping = io_pop_valid && io_pop_ready;

  assign rptr_next = io_flush ? '0 : rptr + {{AW{1'b0}}, popping};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      hazard_q <= 1'b0;
    end else begin
      wptr     <= io_flush ? '0 : wptr + {{AW{1'b0}}, pushing};
      rptr     <= rptr_next;
      hazard_q <= pushing && (wptr[AW-1:0] == rptr_next[AW-1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (pushing) begin
      mem[wptr[AW-1:0]] <= io_push_payload;
    end
    rd_q <= mem[rptr_next[AW-1:0]];
  end

  assign io_pop_payload  = rd_q;
  assign io_occupancy    = occupancy;
  assign io_availability = DEPTH_W - occupancy;

`ifdef STREAM_FIFO_PARAM_WATERMARK_EN
  localparam logic [AW:0] AFULL_W  = (AW+1)'(AFULL_LEVEL);
  localparam logic [AW:0] AEMPTY_W = (AW+1)'(AEMPTY_LEVEL);
  assign io_almostFull  = (occupancy >= AFULL_W);
  assign io_almostEmpty = (occupancy <= AEMPTY_W);
`else
  assign io_almostFull  = 1'b0;
  assign io_almostEmpty = 1'b0;
`endif

endmodule
